// File: rtl/mmio_out_port_pkg.sv
// Shared definitions for the memory-mapped output port: register word
// offsets, status bit positions and the bus FSM state encoding.
package outport_pkg;

    // Word offsets inside the register window (stride = DATA_W/8 bytes).
    // Channel registers follow OFF_CH0; the status word sits after the last channel.
    localparam int OFF_CON = 0;
    localparam int OFF_CH0 = 1;

    // Status word layout
    localparam int ST_CNT_LSB  = 0;
    localparam int ST_CNT_W    = 8;
    localparam int ST_FULL     = 8;
    localparam int ST_OVF      = 9;
    localparam int ST_DROP_LSB = 16;
    localparam int ST_DROP_W   = 16;

    // Bus transaction FSM
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ACK        = 2'd1,
        WAIT_SPACE = 2'd2
    } state_t;

    // Saturating increment for the 16-bit drop counter
    function automatic logic [ST_DROP_W-1:0] sat_inc16(input logic [ST_DROP_W-1:0] v);
        return (v == {ST_DROP_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mmio_out_port_if.sv
// PicoRV32-style native bus as seen by the output port.
// The master holds bus_valid (and the request fields) until it sees bus_ready.
interface mmio_out_port_if #(
    parameter int DATA_W = 32
);
    logic                  bus_valid;
    logic [31:0]           bus_addr;
    logic [DATA_W-1:0]     bus_wdata;
    logic [DATA_W/8-1:0]   bus_wstrb;
    logic                  bus_ready;
    logic [DATA_W-1:0]     bus_rdata;

    modport master (
        output bus_valid, bus_addr, bus_wdata, bus_wstrb,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_addr, bus_wdata, bus_wstrb,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/mmio_out_port_fifo.sv
// Console byte FIFO. Power-of-two depth, pointers wrap naturally.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// While empty, dout keeps showing the last byte popped (0 after reset).
module outport_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    last;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? last : mem[rd_ptr];

    // Pointer, occupancy and last-popped-byte tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last   <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once pushed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_out_port.sv
// Memory-mapped output port: NUM_CH result registers, a console byte FIFO
// drained over valid/ready, and a status word with FIFO level and overflow.
// Optional build macro OUTPORT_DROP_EN: pushes into a full FIFO are acked
// at once and the byte discarded (counted); without it the bus stalls in
// WAIT_SPACE until room appears.
module mmio_out_port
    import outport_pkg::*;
#(
    parameter int          NUM_CH     = 3,
    parameter int          DATA_W     = 32,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    mmio_out_port_if.slave           bus,
    output logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_upd,
    output logic [7:0]               con_byte,
    output logic                     con_valid,
    input  logic                     con_ready
);

    localparam int          BYTES     = DATA_W / 8;
    localparam int          SH        = $clog2(BYTES);
    localparam int          CW        = $clog2(FIFO_DEPTH + 1);
    localparam int          OFF_ST    = NUM_CH + 1;
    localparam logic [31:0] WIN_BYTES = 32'((NUM_CH + 2) * BYTES);

    state_t state;
    state_t nxt;

    // Address decode
    logic [31:0] diff;
    logic [31:0] off;
    logic        in_win;
    logic        is_wr;
    logic        hit_con;
    logic        hit_st;

    // FIFO hookup
    logic          fifo_push;
    logic [7:0]    fifo_din;
    logic          fifo_pop;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_can;

    // Registers and FSM strobes
    logic [NUM_CH-1:0][DATA_W-1:0] ch_q;
    logic [DATA_W-1:0]             rdata_q;
    logic [DATA_W-1:0]             rd_word;
    logic [DATA_W-1:0]             st_word;
    logic [7:0]                    pend_q;
    logic                          ovf_q;
    logic                          accept;
    logic                          ovf_set;
`ifdef OUTPORT_DROP_EN
    logic [ST_DROP_W-1:0]          drop_q;
    logic                          drop_inc;
`endif

    // Addresses below the base wrap to huge differences and fall outside the window
    assign diff    = bus.bus_addr - BASE_ADDR;
    assign off     = diff >> SH;
    assign in_win  = (diff < WIN_BYTES);
    assign is_wr   = |bus.bus_wstrb;
    assign hit_con = (off == 32'(OFF_CON));
    assign hit_st  = (off == 32'(OFF_ST));

    assign fifo_pop  = con_valid && con_ready;
    assign fifo_can  = !fifo_full || fifo_pop;
    assign con_valid = !fifo_empty;

    assign bus.bus_ready = (state == ACK);
    assign bus.bus_rdata = rdata_q;
    assign ch_data       = ch_q;

    outport_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (con_byte),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Status word assembly
    always_comb begin
        st_word = '0;
        st_word[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(fifo_count);
        st_word[ST_FULL]                = fifo_full;
        st_word[ST_OVF]                 = ovf_q;
`ifdef OUTPORT_DROP_EN
        st_word[ST_DROP_LSB +: ST_DROP_W] = drop_q;
`endif
    end

    // Read mux; the console offset reads as zero
    always_comb begin
        rd_word = '0;
        if (hit_st) rd_word = st_word;
        for (int i = 0; i < NUM_CH; i++) begin
            if (off == 32'(i + OFF_CH0)) rd_word = ch_q[i];
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    // FSM next state and per-cycle strobes. A push that meets a full FIFO
    // with a pop in the same cycle goes straight through and is not an overflow.
    always_comb begin
        nxt       = state;
        accept    = 1'b0;
        fifo_push = 1'b0;
        fifo_din  = bus.bus_wdata[7:0];
        ovf_set   = 1'b0;
`ifdef OUTPORT_DROP_EN
        drop_inc  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.bus_valid && in_win) begin
                    accept = 1'b1;
                    nxt    = ACK;
                    if (hit_con && is_wr) begin
                        if (fifo_can) begin
                            fifo_push = 1'b1;
                        end else begin
                            ovf_set = 1'b1;
`ifdef OUTPORT_DROP_EN
                            drop_inc = 1'b1;
`else
                            nxt = WAIT_SPACE;
`endif
                        end
                    end
                end
            end
            ACK: nxt = IDLE;
            WAIT_SPACE: begin
                fifo_din = pend_q;
                if (fifo_can) begin
                    fifo_push = 1'b1;
                    nxt       = ACK;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // Register file, read data capture, overflow and drop bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_q    <= '0;
            ch_upd  <= '0;
            rdata_q <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
`ifdef OUTPORT_DROP_EN
            drop_q  <= '0;
`endif
        end else begin
            ch_upd <= '0;
            if (ovf_set) ovf_q <= 1'b1;
`ifdef OUTPORT_DROP_EN
            if (drop_inc) drop_q <= sat_inc16(drop_q);
`endif
            if (accept) begin
                rdata_q <= is_wr ? '0 : rd_word;
                pend_q  <= bus.bus_wdata[7:0];
                if (is_wr && hit_st && bus.bus_wstrb[0]) ovf_q <= 1'b0;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (is_wr && off == 32'(i + OFF_CH0)) begin
                        ch_upd[i] <= 1'b1;
                        for (int b = 0; b < BYTES; b++) begin
                            if (bus.bus_wstrb[b]) ch_q[i][b*8 +: 8] <= bus.bus_wdata[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

endmodule
